sram_access_scheduler: RTL

- Shares one asynchronous SRAM between a write requester and a read requester.
- Serializes all accesses and uses the SRAM as a circular buffer with internal write and read pointers.
- Generates every SRAM strobe: address, data-bus drive enable, nWE and nOE.
- Sits between the capture/producer logic and the playback/consumer logic, replacing ad-hoc per-direction cycle FSMs.

---
 rtl/sram_access_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sram_access_scheduler.sv
// sram_access_scheduler
//   Shares one asynchronous SRAM between a write requester and a read
//   requester. The SRAM is used as a circular buffer addressed by internal
//   write/read pointers; every SRAM strobe is generated and registered here.
//
// Ports
//   clk, reset        : system clock (rising edge), synchronous active-high reset
//   wr_req, wr_data   : level write request and the word to store
//   wr_ack            : one-cycle pulse when a write has completed
//   rd_req            : level read request for the next stored word
//   rd_data, rd_valid : read word and its one-cycle update pulse
//   full, empty, busy : buffer occupancy and access-in-progress status
//   sram_addr         : registered SRAM address
//   sram_dq_out       : word driven onto the SRAM bus while sram_de=1
//   sram_de           : bus drive enable
//   sram_dq_in        : SRAM bus read-back
//   sram_nwe          : active-low write strobe
//   sram_noe          : active-low output enable
module sram_access_scheduler #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_de,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_nwe,
  output logic              sram_noe
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_SETUP  = 3'd1;
  localparam logic [2:0] W_PULSE  = 3'd2;
  localparam logic [2:0] W_HOLD   = 3'd3;
  localparam logic [2:0] R_SETUP  = 3'd4;
  localparam logic [2:0] R_SAMPLE = 3'd5;

  localparam logic LG_READ  = 1'b0;
  localparam logic LG_WRITE = 1'b1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_grant_q, last_grant_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_dq_out_q, sram_dq_out_d;
  logic              sram_de_q, sram_de_d;
  logic              sram_nwe_q, sram_nwe_d;
  logic              sram_noe_q, sram_noe_d;

  logic wr_elig;
  logic rd_elig;
  logic grant_wr;
  logic grant_rd;

  // Status decoded from registered count and state
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == CNT_W'(0));
  assign busy  = (state_q != IDLE);

  assign wr_ack      = wr_ack_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_de     = sram_de_q;
  assign sram_nwe    = sram_nwe_q;
  assign sram_noe    = sram_noe_q;

  // Round-robin arbitration; on contention the type not granted last wins
  always_comb begin
    wr_elig  = wr_req && !full;
    rd_elig  = rd_req && !empty;
    grant_wr = wr_elig && (!rd_elig || (last_grant_q == LG_READ));
    grant_rd = rd_elig && !grant_wr;
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      last_grant_q  <= LG_READ;
      wr_ack_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_de_q     <= 1'b0;
      sram_nwe_q    <= 1'b1;
      sram_noe_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      last_grant_q  <= last_grant_d;
      wr_ack_q      <= wr_ack_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_de_q     <= sram_de_d;
      sram_nwe_q    <= sram_nwe_d;
      sram_noe_q    <= sram_noe_d;
    end
  end

  // Next-state and strobe sequencing
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    last_grant_d  = last_grant_q;
    wr_ack_d      = 1'b0;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_de_d     = sram_de_q;
    sram_nwe_d    = sram_nwe_q;
    sram_noe_d    = sram_noe_q;

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d       = W_SETUP;
          sram_addr_d   = wr_ptr_q;
          sram_dq_out_d = wr_data;
          sram_de_d     = 1'b1;
          last_grant_d  = LG_WRITE;
        end else if (grant_rd) begin
          state_d      = R_SETUP;
          sram_addr_d  = rd_ptr_q;
          sram_noe_d   = 1'b0;
          last_grant_d = LG_READ;
        end
      end
      // Address and data have had one cycle of setup; open the write pulse
      W_SETUP: begin
        state_d    = W_PULSE;
        sram_nwe_d = 1'b0;
      end
      // Close the pulse; address/data held one more cycle
      W_PULSE: begin
        state_d    = W_HOLD;
        sram_nwe_d = 1'b1;
      end
      W_HOLD: begin
        state_d   = IDLE;
        sram_de_d = 1'b0;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        count_d   = count_q + CNT_W'(1);
        wr_ack_d  = 1'b1;
      end
      // One cycle of access time before sampling the bus
      R_SETUP: begin
        state_d = R_SAMPLE;
      end
      R_SAMPLE: begin
        state_d    = IDLE;
        rd_data_d  = sram_dq_in;
        sram_noe_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
        count_d    = count_q - CNT_W'(1);
        rd_valid_d = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        sram_de_d  = 1'b0;
        sram_nwe_d = 1'b1;
        sram_noe_d = 1'b1;
      end
    endcase
  end

endmodule
